// File: rtl/path_trail_anim.sv
// rtl/path_trail_anim.sv - square path animation (down, right, hold, return) rendered into an OLED pixel stream
// Optional trail rendering: define PATH_TRAIL_ANIM_TRAIL_EN.
module path_trail_anim #(
  parameter int SQ_SIZE  = 5,
  parameter int START_X  = 45,
  parameter int START_Y  = 2,
  parameter int LEG1_LEN = 30,
  parameter int LEG2_LEN = 15,
  parameter int FWD_DIV  = 5000000,
  parameter int RET_DIV  = 10000000,
  parameter int HOLD_CYC = 50000000
) (
  input  logic        bassys_clock,
  input  logic        reset,
  input  logic        btnD,
  input  logic        enable,
  input  logic [12:0] index,
  output logic [15:0] oled_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, DOWN, RIGHT, HOLD_RED, HOLD_GREEN, RETURN, DONE_HOLD} state_t;

  localparam logic [6:0]  SX7       = 7'(START_X);
  localparam logic [6:0]  SY7       = 7'(START_Y);
  localparam logic [6:0]  L1        = 7'(LEG1_LEN);
  localparam logic [6:0]  PTOT      = 7'(LEG1_LEN + LEG2_LEN);
  localparam logic [7:0]  SQ8       = 8'(SQ_SIZE);
  localparam logic [31:0] FWD_LAST  = 32'(FWD_DIV - 1);
  localparam logic [31:0] RET_LAST  = 32'(RET_DIV - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [15:0] RED       = 16'hF800;
  localparam logic [15:0] GREEN     = 16'h07E0;

  state_t      state_q;
  logic [6:0]  sq_x_q, sq_y_q, p_q;
  logic [31:0] cnt_q;
  logic        btn_q, busy_q, done_q;
  logic [15:0] oled_q, oled_d;
  logic [7:0]  px, py;
  logic        in_sq, green_phase;

`ifdef PATH_TRAIL_ANIM_TRAIL_EN
  localparam logic [7:0] SX8  = 8'(START_X);
  localparam logic [7:0] SY8  = 8'(START_Y);
  localparam logic [7:0] L1_8 = 8'(LEG1_LEN);

  logic [6:0] pmax_q;
  logic       replay_q;

  // Union of square footprints for progress values a..b along the L-shaped path
  function automatic logic in_path(input logic [7:0] x, input logic [7:0] y,
                                   input logic [6:0] a, input logic [6:0] b);
    logic [7:0] a8, b8, lo, hi;
    logic       hit;
    a8  = {1'b0, a};
    b8  = {1'b0, b};
    lo  = 8'd0;
    hi  = 8'd0;
    hit = 1'b0;
    if (a8 <= L1_8) begin
      hi = (b8 < L1_8) ? b8 : L1_8;
      if (x >= SX8 && x <= SX8 + SQ8 - 8'd1 && y >= SY8 + a8 && y <= SY8 + hi + SQ8 - 8'd1)
        hit = 1'b1;
    end
    if (b8 >= L1_8) begin
      lo = (a8 > L1_8) ? a8 : L1_8;
      if (x >= SX8 + lo - L1_8 && x <= SX8 + b8 - L1_8 + SQ8 - 8'd1 &&
          y >= SY8 + L1_8 && y <= SY8 + L1_8 + SQ8 - 8'd1)
        hit = 1'b1;
    end
    return hit;
  endfunction
`endif

  // Sequencer: button edge detect, step/hold counter, square position and progress
  always_ff @(posedge bassys_clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sq_x_q   <= SX7;
      sq_y_q   <= SY7;
      p_q      <= 7'd0;
      cnt_q    <= 32'd0;
      btn_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PATH_TRAIL_ANIM_TRAIL_EN
      pmax_q   <= 7'd0;
      replay_q <= 1'b0;
`endif
    end else begin
      btn_q  <= btnD;
      done_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        sq_x_q  <= SX7;
        sq_y_q  <= SY7;
        p_q     <= 7'd0;
        cnt_q   <= 32'd0;
        busy_q  <= 1'b0;
`ifdef PATH_TRAIL_ANIM_TRAIL_EN
        pmax_q  <= 7'd0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (btn_q && !btnD) begin
              state_q <= DOWN;
              cnt_q   <= 32'd0;
              busy_q  <= 1'b1;
`ifdef PATH_TRAIL_ANIM_TRAIL_EN
              pmax_q  <= 7'd0;
`endif
            end
          end
          DOWN: begin
            if (cnt_q == FWD_LAST) begin
              cnt_q  <= 32'd0;
              sq_y_q <= sq_y_q + 7'd1;
              p_q    <= p_q + 7'd1;
`ifdef PATH_TRAIL_ANIM_TRAIL_EN
              pmax_q <= p_q + 7'd1;
`endif
              if (p_q + 7'd1 == L1) state_q <= RIGHT;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          RIGHT: begin
            if (cnt_q == FWD_LAST) begin
              cnt_q  <= 32'd0;
              sq_x_q <= sq_x_q + 7'd1;
              p_q    <= p_q + 7'd1;
`ifdef PATH_TRAIL_ANIM_TRAIL_EN
              pmax_q <= p_q + 7'd1;
`endif
              if (p_q + 7'd1 == PTOT) state_q <= HOLD_RED;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          HOLD_RED, HOLD_GREEN: begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q   <= 32'd0;
              state_q <= (state_q == HOLD_RED) ? HOLD_GREEN : RETURN;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          RETURN: begin
            if (cnt_q == RET_LAST) begin
              cnt_q <= 32'd0;
              p_q   <= p_q - 7'd1;
              if (sq_x_q > SX7) sq_x_q <= sq_x_q - 7'd1;
              else              sq_y_q <= sq_y_q - 7'd1;
              if (p_q == 7'd1) state_q <= DONE_HOLD;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          DONE_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q    <= 32'd0;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
`ifdef PATH_TRAIL_ANIM_TRAIL_EN
              replay_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign px          = 8'(index % 13'd96);
  assign py          = 8'(index / 13'd96);
  assign in_sq       = (px >= {1'b0, sq_x_q}) && (px <= {1'b0, sq_x_q} + SQ8 - 8'd1) &&
                       (py >= {1'b0, sq_y_q}) && (py <= {1'b0, sq_y_q} + SQ8 - 8'd1);
  assign green_phase = (state_q == HOLD_GREEN) || (state_q == RETURN) || (state_q == DONE_HOLD);

  // Pixel colour for the index presented this cycle
  always_comb begin
    oled_d = 16'h0000;
    if (index < 13'd6144) begin
      if (in_sq) begin
        oled_d = green_phase ? GREEN : RED;
      end
`ifdef PATH_TRAIL_ANIM_TRAIL_EN
      else if (state_q == IDLE && replay_q) begin
        if (in_path(px, py, 7'd0, PTOT)) oled_d = GREEN;
      end else if (in_path(px, py, p_q, pmax_q)) begin
        oled_d = GREEN;
      end else if (in_path(px, py, 7'd0, pmax_q)) begin
        oled_d = RED;
      end
`endif
    end
  end

  // Registered pixel output, one cycle behind index
  always_ff @(posedge bassys_clock) begin
    if (reset) oled_q <= 16'h0000;
    else       oled_q <= oled_d;
  end

  assign oled_data = oled_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
